// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg: shared loader FSM states and protocol constants
package rom_loader_pkg;
    typedef enum logic [2:0] {IDLE, CNT_HI, CNT_LO, DATA_HI, DATA_LO, WRITE, DONE, ERR} state_t;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int MAX_WORDS = 32768;
    localparam int ROM_ADDR_W = 15;
endpackage

// File: rtl/rom_loader_uart_rx.sv
// uart_rx: 8N1 receiver with 2-FF synchronizer and mid-bit sampling
module uart_rx #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD = 115200
) (
    input  logic       clk_in,
    input  logic       reset_n,
    input  logic       rx,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       rx_ferr
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW = $clog2(DIV);
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    logic s1, s2;
    rx_state_t st;
    logic [CW-1:0] cnt;
    logic [2:0] bitn;
    logic [7:0] sh;
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            st <= R_IDLE;
            cnt <= '0;
            bitn <= '0;
            sh <= '0;
            rx_valid <= 1'b0;
            rx_byte <= '0;
            rx_ferr <= 1'b0;
        end else begin
            s1 <= rx;
            s2 <= s1;
            rx_valid <= 1'b0;
            case (st)
                R_IDLE: if (!s2) begin
                    st <= R_START;
                    cnt <= '0;
                end
                // a start bit that is high again at half a bit period was a glitch
                R_START: if (cnt == CW'(DIV / 2 - 1)) begin
                    st <= s2 ? R_IDLE : R_DATA;
                    cnt <= '0;
                    bitn <= '0;
                end else cnt <= cnt + CW'(1);
                R_DATA: if (cnt == CW'(DIV - 1)) begin
                    cnt <= '0;
                    sh <= {s2, sh[7:1]};
                    bitn <= bitn + 3'd1;
                    if (bitn == 3'd7) st <= R_STOP;
                end else cnt <= cnt + CW'(1);
                R_STOP: if (cnt == CW'(DIV - 1)) begin
                    st <= R_IDLE;
                    rx_valid <= 1'b1;
                    rx_byte <= sh;
                    rx_ferr <= !s2;
                end else cnt <= cnt + CW'(1);
                default: st <= R_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/rom_loader.sv
// rom_loader: receives a sync/count/words UART stream and writes it into the instruction ROM
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD = 115200,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic                  clk_in,
    input  logic                  reset_n,
    input  logic                  uart_rx,
    output logic                  rom_we,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    output logic [15:0]           rom_data,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  load_done,
    output logic                  load_err
);
    localparam int TW = $clog2(TIMEOUT + 1);
    logic rx_valid, rx_ferr;
    logic [7:0] rx_byte, cnt_hi_b, data_hi_b;
    logic [15:0] n_words;
    logic [TW-1:0] idle_cnt;
    state_t state;
    logic tmo, waiting;
    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_rx (
        .clk_in(clk_in), .reset_n(reset_n), .rx(uart_rx),
        .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_ferr(rx_ferr)
    );
    assign tmo = idle_cnt == TW'(TIMEOUT);
    assign waiting = state inside {CNT_HI, CNT_LO, DATA_HI, DATA_LO};
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            idle_cnt <= '0;
            cnt_hi_b <= '0;
            data_hi_b <= '0;
            n_words <= '0;
            rom_we <= 1'b0;
            rom_addr <= '0;
            rom_data <= '0;
            cpu_hold <= 1'b0;
            busy <= 1'b0;
            load_done <= 1'b0;
            load_err <= 1'b0;
        end else begin
            idle_cnt <= rx_valid ? '0 : tmo ? idle_cnt : idle_cnt + TW'(1);
            rom_we <= 1'b0;
            load_done <= 1'b0;
            // a byte arriving with the timeout wins; cpu_hold stays up since the ROM is partial
            if (waiting && (rx_valid ? rx_ferr : tmo)) begin
                state <= ERR;
                load_err <= 1'b1;
                busy <= 1'b0;
            end else case (state)
                IDLE, ERR: if (rx_valid && !rx_ferr && rx_byte == SYNC_BYTE) begin
                    state <= CNT_HI;
                    load_err <= 1'b0;
                    rom_addr <= '0;
                    cpu_hold <= 1'b1;
                    busy <= 1'b1;
                end
                CNT_HI: if (rx_valid) begin
                    cnt_hi_b <= rx_byte;
                    state <= CNT_LO;
                end
                CNT_LO: if (rx_valid) begin
                    n_words <= {cnt_hi_b, rx_byte};
                    if ({cnt_hi_b, rx_byte} == 16'd0) begin
                        state <= DONE;
                        load_done <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else if ({cnt_hi_b, rx_byte} > 16'(MAX_WORDS)) begin
                        state <= ERR;
                        load_err <= 1'b1;
                        busy <= 1'b0;
                    end else state <= DATA_HI;
                end
                DATA_HI: if (rx_valid) begin
                    data_hi_b <= rx_byte;
                    state <= DATA_LO;
                end
                DATA_LO: if (rx_valid) begin
                    rom_data <= {data_hi_b, rx_byte};
                    rom_we <= 1'b1;
                    state <= WRITE;
                end
                WRITE: begin
                    rom_addr <= rom_addr + ROM_ADDR_W'(1);
                    if (16'(rom_addr) + 16'd1 == n_words) begin
                        state <= DONE;
                        load_done <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else state <= DATA_HI;
                end
                DONE: begin
                    state <= IDLE;
                    busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: randomized UART streams checked against a byte-level protocol model
module tb_rom_loader;
    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD = 100_000;
    localparam int DIV = 16;
    localparam int TIMEOUT = 400;
    typedef struct {int addr; int data;} wr_t;
    logic clk_in = 1'b0;
    logic reset_n = 1'b0;
    logic uart_rx = 1'b1;
    logic rom_we, cpu_hold, busy, load_done, load_err;
    logic [14:0] rom_addr;
    logic [15:0] rom_data;
    int errors = 0;
    int checks = 0;
    longint cyc = 0;
    wr_t exp_q[$];
    wr_t w;
    bit m_active = 0, m_err = 0, m_hold = 0;
    int m_pos = 0, m_n = 0, m_hi = 0, m_done = 0;
    int done_seen = 0, we_seen = 0;
    longint last_we_cyc = 0, last_done_cyc = 0;
    bit saw_activity = 0;
    int cap_addr[$], cap_data[$];
    int snap_done, snap_we;
    rom_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .TIMEOUT(TIMEOUT)) dut (
        .clk_in(clk_in), .reset_n(reset_n), .uart_rx(uart_rx),
        .rom_we(rom_we), .rom_addr(rom_addr), .rom_data(rom_data),
        .cpu_hold(cpu_hold), .busy(busy), .load_done(load_done), .load_err(load_err)
    );
    always #5 clk_in = ~clk_in;
    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask
    task automatic model_byte(input logic [7:0] b, input bit ferr);
        if (!m_active) begin
            if (!ferr && b == 8'hA5) begin
                m_active = 1; m_pos = 0; m_err = 0; m_hold = 1;
            end
            return;
        end
        if (ferr) begin
            m_active = 0; m_err = 1;
            return;
        end
        m_pos++;
        if (m_pos == 1) m_n = b * 256;
        else if (m_pos == 2) begin
            m_n += b;
            if (m_n == 0) begin
                m_active = 0; m_hold = 0; m_done++;
            end else if (m_n > 32768) begin
                m_active = 0; m_err = 1;
            end
        end else if ((m_pos - 3) % 2 == 0) m_hi = b;
        else begin
            exp_q.push_back(wr_t'{(m_pos - 4) / 2, m_hi * 256 + b});
            if ((m_pos - 4) / 2 + 1 == m_n) begin
                m_active = 0; m_hold = 0; m_done++;
            end
        end
    endtask
    task automatic model_timeout();
        if (m_active) begin
            m_active = 0; m_err = 1;
        end
    endtask
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk_in);
        #2;
    endtask
    task automatic send_byte(input logic [7:0] b, input bit stop);
        model_byte(b, !stop);
        uart_rx = 1'b0;
        wait_cycles(DIV);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            wait_cycles(DIV);
        end
        uart_rx = stop;
        wait_cycles(DIV);
        uart_rx = 1'b1;
        if (!stop) wait_cycles(2 * DIV);
    endtask
    task automatic send_list(input logic [7:0] bs[$], input int gap_max);
        foreach (bs[i]) begin
            send_byte(bs[i], 1'b1);
            wait_cycles($urandom_range(gap_max, 0));
        end
    endtask
    task automatic settle(input string tag);
        wait_cycles(30);
        check({tag, "_load_err"}, load_err, m_err);
        check({tag, "_cpu_hold"}, cpu_hold, m_hold);
        check({tag, "_busy"}, busy, m_active);
        check({tag, "_pending_writes"}, exp_q.size(), 0);
        check({tag, "_done_count"}, done_seen, m_done);
    endtask
    always @(posedge clk_in) begin
        #1;
        cyc++;
        if (reset_n) begin
            if (busy || cpu_hold || rom_we || load_done) saw_activity = 1;
            if (rom_we) begin
                we_seen++;
                last_we_cyc = cyc;
                cap_addr.push_back(int'(rom_addr));
                cap_data.push_back(int'(rom_data));
                if (exp_q.size() == 0) check("unexpected_rom_we", 1, 0);
                else begin
                    w = exp_q.pop_front();
                    check("we_addr", rom_addr, w.addr);
                    check("we_data", rom_data, w.data);
                end
                check("we_cpu_hold", cpu_hold, 1);
            end
            if (load_done) begin
                done_seen++;
                last_done_cyc = cyc;
                check("done_cpu_hold", cpu_hold, 0);
                check("done_busy", busy, 1);
            end
        end
    end
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 2000000", $time);
        $fatal(1);
    end
    initial begin
        logic [7:0] q[$];
        int n;
        wait_cycles(4);
        check("reset_rom_we", rom_we, 0);
        check("reset_cpu_hold", cpu_hold, 0);
        check("reset_busy", busy, 0);
        check("reset_load_done", load_done, 0);
        check("reset_load_err", load_err, 0);
        check("reset_rom_addr", rom_addr, 0);
        reset_n = 1'b1;
        wait_cycles(20);
        cap_addr.delete(); cap_data.delete();
        send_list('{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD}, 10);
        settle("normal");
        check("normal_writes", cap_addr.size(), 2);
        if (cap_addr.size() == 2) begin
            check("normal_addr0", cap_addr[0], 0);
            check("normal_data0", cap_data[0], 16'h1234);
            check("normal_addr1", cap_addr[1], 1);
            check("normal_data1", cap_data[1], 16'hABCD);
        end
        check("normal_done_latency", last_done_cyc, last_we_cyc + 1);
        saw_activity = 0;
        send_list('{8'h00, 8'hFF, 8'h5A}, 10);
        uart_rx = 1'b0;
        wait_cycles(4);
        uart_rx = 1'b1;
        settle("noise");
        check("noise_no_activity", saw_activity, 0);
        snap_done = done_seen; snap_we = we_seen;
        send_list('{8'hA5, 8'h00, 8'h00}, 10);
        settle("empty");
        check("empty_done_once", done_seen - snap_done, 1);
        check("empty_no_write", we_seen - snap_we, 0);
        snap_we = we_seen;
        send_list('{8'hA5, 8'h80, 8'h01}, 10);
        settle("oversize");
        check("oversize_err_lit", load_err, 1);
        check("oversize_hold_lit", cpu_hold, 1);
        check("oversize_no_write", we_seen - snap_we, 0);
        send_list('{8'hA5, 8'h00, 8'h00}, 10);
        settle("recover");
        check("recover_err_lit", load_err, 0);
        snap_we = we_seen;
        send_list('{8'hA5, 8'h00, 8'h01, 8'h12}, 10);
        wait_cycles(500);
        model_timeout();
        settle("timeout");
        check("timeout_err_lit", load_err, 1);
        check("timeout_no_write", we_seen - snap_we, 0);
        send_list('{8'hA5, 8'h00}, 10);
        send_byte(8'h01, 1'b0);
        settle("ferr");
        check("ferr_err_lit", load_err, 1);
        send_list('{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34}, 10);
        #1;
        reset_n = 1'b0;
        #1;
        check("midreset_outputs", {rom_we, cpu_hold, busy, load_done, load_err}, 0);
        check("midreset_addr", rom_addr, 0);
        check("midreset_data", rom_data, 0);
        m_active = 0; m_err = 0; m_hold = 0; exp_q.delete();
        wait_cycles(5);
        reset_n = 1'b1;
        wait_cycles(5);
        cap_addr.delete(); cap_data.delete();
        send_list('{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD}, 10);
        settle("after_reset");
        check("after_reset_writes", cap_addr.size(), 2);
        for (int it = 0; it < 6; it++) begin
            int ferr_at;
            q.delete();
            repeat ($urandom_range(2, 0)) begin
                logic [7:0] nb;
                nb = 8'($urandom_range(255, 0));
                if (nb == 8'hA5) nb = 8'h3C;
                q.push_back(nb);
            end
            n = $urandom_range(4, 1);
            q.push_back(8'hA5);
            q.push_back(8'h00);
            q.push_back(8'(n));
            repeat (2 * n) q.push_back(8'($urandom_range(255, 0)));
            ferr_at = ($urandom_range(2, 0) == 0) ? $urandom_range(q.size() - 1, 0) : -1;
            foreach (q[i]) begin
                send_byte(q[i], i != ferr_at);
                wait_cycles($urandom_range(20, 0));
            end
            if (m_active) begin
                wait_cycles(450);
                model_timeout();
            end
            settle("random");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, UART bit rate; bit period DIV = CLK_FREQ/BAUD cycles.
REQ-003 Parameter TIMEOUT, default 1_000_000, maximum idle cycles between bytes while a load is in progress.
REQ-004 clk_in  input  1  sole clock, rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 uart_rx  input  1  asynchronous serial line, 8N1, idle high.
REQ-007 rom_we  output  1  one-cycle instruction-ROM write strobe.
REQ-008 rom_addr  output  15  ROM word address for the current write.
REQ-009 rom_data  output  16  instruction word for the current write.
REQ-010 cpu_hold  output  1  high while the CPU must be held in reset; ORed into the CPU reset by the top level.
REQ-011 busy  output  1  high in any state other than IDLE and ERR.
REQ-012 load_done  output  1  one-cycle pulse on successful completion.
REQ-013 load_err  output  1  sticky error flag.

Function
REQ-014 Protocol, in order: sync byte 0xA5; word count N as 2 bytes, MSB first; N words, each as 2 bytes, MSB first.
REQ-015 States: IDLE, CNT_HI, CNT_LO, DATA_HI, DATA_LO, WRITE, DONE, ERR.
REQ-016 IDLE: bytes other than 0xA5 are ignored; 0xA5 -> CNT_HI, clears load_err, zeroes the address counter.
REQ-017 CNT_HI -> CNT_LO -> (N==0: DONE; N>32768: ERR; else DATA_HI), one received byte per transition.
REQ-018 DATA_HI latches the high byte; DATA_LO latches the low byte and goes to WRITE.
REQ-019 WRITE lasts exactly one cycle with rom_we=1 and rom_addr/rom_data valid.
REQ-020 After WRITE the address increments; if N words have been written -> DONE, else -> DATA_HI.
REQ-021 Address wrap is impossible because N is capped at 32768 (last address 0x7FFF).
REQ-022 Latency: rom_we asserts on the cycle after the rx_valid of the low byte.
REQ-023 DONE lasts one cycle: load_done=1, cpu_hold falls on the same cycle, then -> IDLE.
REQ-024 cpu_hold rises on the cycle after the sync byte is accepted.
REQ-025 cpu_hold stays high through ERR, because ROM contents are then partial.
REQ-026 Timeout: the idle-cycle counter resets on every received byte; if it exceeds TIMEOUT in CNT_*/DATA_* -> ERR.
REQ-027 A framing error (stop bit sampled 0) in any non-IDLE state -> ERR; in IDLE the byte is dropped.
REQ-028 ERR: load_err=1, rom_we=0; only an 0xA5 byte leaves ERR (-> CNT_HI).
REQ-029 A byte completing on the same cycle as a timeout: the byte wins and the counter resets.
REQ-030 UART receiver: 2-FF synchronizer; start bit confirmed at DIV/2, otherwise discarded as a glitch.
REQ-031 UART data sampling: data sampled at mid-bit, LSB first; a one-cycle rx_valid/rx_byte/rx_ferr issued after the stop-bit sample.

Reset
REQ-032 reset_n low at any time, including mid-load: state IDLE, all outputs 0, counters and latched bytes 0.
REQ-033 The receiver also returns to idle; the first byte after release requires a full start bit.

Structure
REQ-034 Shared package holds the state enum, SYNC_BYTE=8'hA5, MAX_WORDS=32768, and ROM_ADDR_W=15.
REQ-035 Sub-module uart_rx (parameters CLK_FREQ and BAUD) provides the receiver; rom_loader holds the FSM, count, address and timeout logic.

Verification (CLK_FREQ=1_600_000, BAUD=100_000 giving DIV=16, TIMEOUT=400)
REQ-036 Normal load: A5 00 02 12 34 AB CD -> two rom_we pulses (addr 0x0000/0x1234, addr 0x0001/0xABCD), then one load_done pulse the cycle after the second write, with cpu_hold falling on that same cycle.
REQ-037 Empty load: A5 00 00 -> no rom_we, load_done pulses once, cpu_hold high for the A5..count window only.
REQ-038 Oversize count: A5 80 01 -> ERR, load_err=1, no rom_we, cpu_hold=1; a following A5 00 00 clears load_err and pulses load_done.
REQ-039 Timeout: A5 00 01 12 then 500 idle cycles -> ERR with no write; a framing error on the 3rd byte likewise -> ERR.
REQ-040 Mid-load reset: reset_n low after byte 5 of the REQ-036 stream -> all outputs 0 immediately; a fresh REQ-036 stream then succeeds.
REQ-041 Noise in IDLE: bytes 00 FF 5A and a 4-cycle low glitch -> no state change and no outputs asserted.
